ip_codma_bus_slave_mem: RTL
===========================

// Module: ip_codma_bus_slave_mem
// PURPOSE
//  Memory-backed responder for the BUS_IF slave modport: the target end of the CODMA bus.
//  Arbitrates nothing: services one read or write at a time from a single master.
//  Handles single double-word and 2/4 double-word incrementing bursts, and flags illegal requests.
//  Used as the data store behind the CODMA engine in subsystem builds and as the bench target.
// PARAMETERS
//  MEM_DWORDS  256       depth of storage in 64-bit double-words (power of 2, >=4)
//  BASE_ADDR   32'h0     byte address of double-word 0; must be 8-byte aligned
//  GRANT_WAIT  0         idle cycles inserted between request seen and grant (0..15)
// PORTS
//  clk         input   1        bus clock; all logic on rising edge
//  reset       input   1        synchronous, active-high reset
//  bus         BUS_IF.slave     read/write/addr[31:0]/size[3:0]/write_data[63:0]/write_valid in;
//                               grant/read_data[63:0]/read_valid/error out
// BEHAVIOUR
//  size encoding: 4'b0001 = 1 DW, 4'b0010 = 2 DW burst, 4'b0100 = 4 DW burst; any other value is illegal.
//  Reset: grant=0, read_valid=0, read_data=0, error=0, FSM=IDLE, counters=0.
//   Memory contents are not cleared.
//  FSM: IDLE -> WAIT -> GRANT -> {RDATA | WDATA | ERR} -> IDLE.
//  IDLE: request = read|write.
//   If a request is present and GRANT_WAIT==0, go to GRANT; otherwise go to WAIT and load wait_cnt=GRANT_WAIT-1.
//  WAIT: decrement wait_cnt; at 0 go to GRANT.
//   If the request drops during WAIT, return to IDLE with no grant.
//  GRANT: grant=1 for exactly one cycle.
//   Capture addr, size, and direction (read/write) in this cycle.
//   The master drops read/write in the cycle after it sees grant.
//  Legality check on captured values (all must hold, else go to ERR):
//   - read XOR write
//   - size legal
//   - addr[2:0]==0
//   - addr >= BASE_ADDR
//   - last byte = addr + 8*N - 1 < BASE_ADDR + 8*MEM_DWORDS
//   - compute the bound in 33 bits so there is no 32-bit overflow; a burst that would wrap is illegal.
//  ERR: error=1 for one cycle (the cycle after grant). No memory access, no read_valid.
//   Then IDLE. The master must not drive write_valid for an errored write; any it does drive is ignored.
//  RDATA: idx = (addr-BASE_ADDR)>>3.
//   read_valid=1 for N consecutive cycles starting the cycle after grant, no gaps.
//   Beat k returns read_data = mem[idx+k]. Incrementing only, no wrap.
//   read_data=0 whenever read_valid=0. Return to IDLE after beat N-1.
//  WDATA: on each cycle with write_valid=1, write mem[idx+beat]=write_data and increment beat.
//   Gaps (write_valid=0) are allowed and stall indefinitely.
//   Return to IDLE in the cycle after beat N-1 is written.
//   write_valid in the grant cycle itself is ignored.
//  No new request is sampled outside IDLE. read/write held during RDATA/WDATA/ERR are ignored.
//   IDLE evaluates a request only from the cycle after returning to IDLE.
//  Back-to-back: minimum one IDLE cycle between transactions.
//   Earliest next grant is 2 cycles after the last data beat (GRANT_WAIT=0).
//  Read-after-write to the same address returns the new data; memory is write-first.
//  Reset asserted mid-transaction: abort immediately, FSM=IDLE, outputs as reset values.
//   Beats already written remain in memory.
//  Latency (GRANT_WAIT=0): request cycle t -> grant t+1 -> first read beat/error t+2.
// TESTING
//  1 DW write 0xDEADBEEF_CAFEF00D @0x10, then 1 DW read @0x10
//   -> grant 1 cycle after each request; read_valid 1 cycle with that data.
//  4 DW write @0x20 with a gap cycle between beats 1 and 2, then 4 DW read @0x20
//   -> 4 contiguous read_valid beats in write order.
//  Illegal size 4'b0011, unaligned addr 0x0C, and a burst ending past MEM_DWORDS*8 -> grant, then 1-cycle error;
//   memory is unchanged and no read_valid.
//  read and write asserted together -> grant, then error. A subsequent legal read still works.
//  GRANT_WAIT=3: grant 4 cycles after the request; request dropped in WAIT -> no grant, FSM back to IDLE.
//  Reset during beat 2 of a 4 DW write -> outputs zero next cycle; beats 0-1 are readable afterwards, beats 2-3 keep old data.

Source files
------------

// File: rtl/ip_codma_bus_slave_mem_if.sv
// CODMA bus bundle between a single master and the memory responder.
// Request/grant handshake; read beats are unthrottled, write beats are paced by write_valid.
interface ip_codma_bus_slave_mem_if;
   logic        read;
   logic        write;
   logic [31:0] addr;
   logic [3:0]  size;
   logic [63:0] write_data;
   logic        write_valid;
   logic        grant;
   logic [63:0] read_data;
   logic        read_valid;
   logic        error;

   modport master (
      output read, write, addr, size, write_data, write_valid,
      input  grant, read_data, read_valid, error
   );

   modport slave (
      input  read, write, addr, size, write_data, write_valid,
      output grant, read_data, read_valid, error
   );
endinterface

// File: rtl/ip_codma_bus_slave_mem.sv
// Memory-backed CODMA bus target: 1/2/4 double-word incrementing bursts, illegal requests get a 1-cycle error.
// Grant 1+GRANT_WAIT cycles after request, first read beat/error one cycle later; write beats stall on write_valid=0.
module ip_codma_bus_slave_mem #(
   parameter int          MEM_DWORDS = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          GRANT_WAIT = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   ip_codma_bus_slave_mem_if.slave bus
);

   localparam int          IW        = $clog2(MEM_DWORDS);
   localparam logic [32:0] MEM_BYTES = 33'(MEM_DWORDS) << 3;
   localparam logic [3:0]  WAIT_LOAD = (GRANT_WAIT == 0) ? 4'd0 : 4'(GRANT_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_GRANT, S_RDATA, S_WDATA, S_ERR
   } state_t;

   state_t        state, state_nxt;
   logic [3:0]    wait_cnt, wait_cnt_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [1:0]    beat, beat_nxt;
   logic [1:0]    last, last_nxt;
   logic [IW-1:0] mem_addr;
   logic          mem_we;
   logic [63:0]   mem [MEM_DWORDS];

   logic          size_ok;
   logic [1:0]    req_last;
   logic [31:0]   off;
   logic [32:0]   end_off;
   logic          legal;

   // Bound is checked as an offset in 33 bits so a burst that wraps past 2^32 is rejected.
   always_comb begin
      size_ok  = 1'b1;
      req_last = 2'd0;
      case (bus.size)
         4'b0001: req_last = 2'd0;
         4'b0010: req_last = 2'd1;
         4'b0100: req_last = 2'd3;
         default: size_ok  = 1'b0;
      endcase
      off     = bus.addr - BASE_ADDR;
      end_off = {1'b0, off} + {27'd0, 3'(req_last) + 3'd1, 3'b000};
      legal   = (bus.read ^ bus.write) && size_ok && (bus.addr[2:0] == 3'b000)
                && (bus.addr >= BASE_ADDR) && (end_off <= MEM_BYTES);
   end

   assign mem_addr = idx + IW'(beat);

   always_comb begin
      state_nxt      = state;
      wait_cnt_nxt   = wait_cnt;
      idx_nxt        = idx;
      beat_nxt       = beat;
      last_nxt       = last;
      mem_we         = 1'b0;
      bus.grant      = 1'b0;
      bus.read_valid = 1'b0;
      bus.read_data  = 64'd0;
      bus.error      = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.read || bus.write) begin
               if (GRANT_WAIT == 0) begin
                  state_nxt = S_GRANT;
               end else begin
                  state_nxt    = S_WAIT;
                  wait_cnt_nxt = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (!(bus.read || bus.write)) begin
               state_nxt = S_IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_nxt = S_GRANT;
            end else begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
         end
         S_GRANT: begin
            bus.grant = 1'b1;
            idx_nxt   = off[IW+2:3];
            last_nxt  = req_last;
            beat_nxt  = 2'd0;
            if (!legal)        state_nxt = S_ERR;
            else if (bus.read) state_nxt = S_RDATA;
            else               state_nxt = S_WDATA;
         end
         S_RDATA: begin
            bus.read_valid = 1'b1;
            bus.read_data  = mem[mem_addr];
            if (beat == last) state_nxt = S_IDLE;
            else              beat_nxt  = beat + 2'd1;
         end
         S_WDATA: begin
            if (bus.write_valid) begin
               mem_we = 1'b1;
               if (beat == last) state_nxt = S_IDLE;
               else              beat_nxt  = beat + 2'd1;
            end
         end
         S_ERR: begin
            bus.error = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         idx      <= '0;
         beat     <= 2'd0;
         last     <= 2'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         idx      <= idx_nxt;
         beat     <= beat_nxt;
         last     <= last_nxt;
      end
   end

   // Storage is never cleared; a beat coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_addr] <= bus.write_data;
      end
   end

endmodule
